keycode_autopilot: RTL and testbench
====================================

// Module: keycode_autopilot
// PURPOSE
//  Produces the 16-bit keycode bus consumed by the ball movement logic.
//  Forwards live keyboard keycodes while a user is active. After a sustained
//  idle period it switches to demo (attract) mode and plays a fixed script of
//  WASD keycodes, one key per script step, each held for a set number of frames.
//  Sits between the USB/NIOS keycode source and the ball module.
//  All timing is in frames.
// PARAMETERS
//  IDLE_FRAMES  600  consecutive all-zero live frames before demo entry (>=1)
//  DEMO_LOOP    1    1: script wraps idx 7->0; 0: after idx 7 return to LIVE
// PORTS
//  frame_clk     in   1   clock, one edge per video frame
//  Reset         in   1   asynchronous, active-high
//  live_keycode  in   16  live keycodes {key1[15:8], key0[7:0]}; 0 = no key
//  demo_enable   in   1   1 permits demo mode; 0 forces/keeps LIVE
//  keycode_out   out  16  registered keycode to ball logic
//  demo_active   out  1   1 while state==DEMO
//  script_idx    out  3   current script step (0 when not in DEMO)
// BEHAVIOUR
//  Reset (async): state=LIVE, keycode_out=0, demo_active=0, script_idx=0,
//   idle_cnt=0, dur_cnt=0. Reset mid-demo aborts immediately to these values.
//  Script ROM, idx: key/frames. 0:07/40  1:16/40  2:04/40  3:1A/40
//   4:07/20  5:1A/20  6:04/20  7:16/20. Keys are USB HID d,s,a,w.
//   Demo output = {8'h00, key[idx]}.
//  idle_cnt width = $clog2(IDLE_FRAMES+1). It saturates at IDLE_FRAMES-1.
//  dur_cnt is 8 bits. A duration of 0 is treated as 1.
//  LIVE, each edge:
//   - keycode_out <= live_keycode. Latency is 1 frame.
//   - live!=0 or demo_enable=0: idle_cnt <= 0.
//   - live==0, demo_enable=1, idle_cnt <  IDLE_FRAMES-1: idle_cnt++.
//   - live==0, demo_enable=1, idle_cnt == IDLE_FRAMES-1: state <= DEMO,
//     script_idx <= 0, dur_cnt <= 0, keycode_out <= {8'h00, key[0]}.
//     demo_active rises on this edge.
//   - Net effect: the first demo key appears on the IDLE_FRAMES-th
//     consecutive zero-sampled edge.
//  DEMO, each edge, in priority order:
//   1) live!=0 or demo_enable=0: state <= LIVE, keycode_out <= live_keycode
//      (same edge, no lost key). idle_cnt, dur_cnt, script_idx <= 0.
//   2) dur_cnt == dur[idx]-1:
//      - idx<7: idx++, dur_cnt <= 0.
//      - idx==7, DEMO_LOOP=1: idx <= 0.
//      - idx==7, DEMO_LOOP=0: state <= LIVE, idle_cnt <= 0,
//        keycode_out <= 0.
//      keycode_out <= key[new idx] when staying in DEMO.
//   3) Otherwise: dur_cnt++, keycode_out holds.
//  Resulting step timing: key[idx] is output for exactly dur[idx] frames.
//   Full script period = 240 frames.
//  key1 byte is always 0 in DEMO. In LIVE both bytes pass through unchanged.
// TESTING (bench uses IDLE_FRAMES=4)
//  1 Reset asserted mid-frame -> keycode_out=0, demo_active=0, script_idx=0
//    asynchronously.
//  2 live=001A at edge n -> keycode_out=001A after edge n. live=0 at edge n+1
//    -> keycode_out=0000 after edge n+1.
//  3 live=0, demo_enable=1 for 4 edges -> after edge 4: demo_active=1,
//    keycode_out=0007. After 40 more edges: 0016, script_idx=1.
//  4 Run 240 demo frames -> idx walks 0..7 with durations 40x4 then 20x4,
//    then wraps to idx 0 and keycode_out=0007. With DEMO_LOOP=0: LIVE,
//    keycode_out=0000, re-enters DEMO 4 frames later.
//  5 Mid-demo (idx 2), live=0416 for one edge -> same edge: demo_active=0,
//    keycode_out=0416. Demo re-entry requires 4 fresh zero frames.
//  6 demo_enable=0 during DEMO -> LIVE next edge. demo_enable=0 with live=0
//    for 100 edges -> never enters DEMO, idle_cnt stays 0.

Source files
------------

// File: rtl/keycode_autopilot_if.sv
// Keycode bus between the live keycode source, the autopilot and the ball logic.
// The master side supplies live keys and the demo permit; the slave side returns the keycode.
interface keycode_autopilot_if;
  logic [15:0] live_keycode;
  logic        demo_enable;
  logic [15:0] keycode_out;
  logic        demo_active;
  logic [2:0]  script_idx;

  modport master (
    output live_keycode, demo_enable,
    input  keycode_out, demo_active, script_idx
  );

  modport slave (
    input  live_keycode, demo_enable,
    output keycode_out, demo_active, script_idx
  );
endinterface

// File: rtl/keycode_autopilot.sv
// Forwards live keycodes to the ball logic. After a sustained idle period it
// plays a fixed WASD attract script until a user presses a key again.
module keycode_autopilot #(
  parameter int IDLE_FRAMES = 600,
  parameter bit DEMO_LOOP   = 1'b1
) (
  input  logic               frame_clk,
  input  logic               Reset,
  keycode_autopilot_if.slave bus
);

  localparam int IW = $clog2(IDLE_FRAMES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_FRAMES - 1);

  typedef enum logic {LIVE, DEMO} state_t;

  state_t      r_state;
  logic [15:0] r_keycode;
  logic        r_demoActive;
  logic [2:0]  r_idx;
  logic [IW-1:0] r_idleCnt;
  logic [7:0]  r_durCnt;

  logic        w_liveIdle;
  logic [7:0]  w_durLast;
  logic [2:0]  w_idxNext;

  // USB HID keys d, s, a, w
  function automatic logic [7:0] keyOf(input logic [2:0] idx);
    case (idx)
      3'd0: keyOf = 8'h07;
      3'd1: keyOf = 8'h16;
      3'd2: keyOf = 8'h04;
      3'd3: keyOf = 8'h1A;
      3'd4: keyOf = 8'h07;
      3'd5: keyOf = 8'h1A;
      3'd6: keyOf = 8'h04;
      default: keyOf = 8'h16;
    endcase
  endfunction

  function automatic logic [7:0] durOf(input logic [2:0] idx);
    durOf = idx[2] ? 8'd20 : 8'd40;
  endfunction

  // A zero duration behaves as a one-frame step
  assign w_durLast  = (durOf(r_idx) == 8'd0) ? 8'd0 : durOf(r_idx) - 8'd1;
  assign w_liveIdle = (bus.live_keycode == 16'h0000) && bus.demo_enable;
  assign w_idxNext  = r_idx + 3'd1;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= LIVE;
      r_keycode    <= 16'h0000;
      r_demoActive <= 1'b0;
      r_idx        <= 3'd0;
      r_idleCnt    <= '0;
      r_durCnt     <= 8'd0;
    end else begin
      case (r_state)
        LIVE: begin
          r_keycode <= bus.live_keycode;
          if (!w_liveIdle) begin
            r_idleCnt <= '0;
          end else if (r_idleCnt == IDLE_LAST) begin
            r_state      <= DEMO;
            r_demoActive <= 1'b1;
            r_idx        <= 3'd0;
            r_durCnt     <= 8'd0;
            r_idleCnt    <= '0;
            r_keycode    <= {8'h00, keyOf(3'd0)};
          end else begin
            r_idleCnt <= r_idleCnt + 1'b1;
          end
        end
        DEMO: begin
          // A live key wins on the same edge so the user's press is never dropped
          if (!w_liveIdle) begin
            r_state      <= LIVE;
            r_demoActive <= 1'b0;
            r_keycode    <= bus.live_keycode;
            r_idleCnt    <= '0;
            r_durCnt     <= 8'd0;
            r_idx        <= 3'd0;
          end else if (r_durCnt == w_durLast) begin
            r_durCnt <= 8'd0;
            if (r_idx != 3'd7) begin
              r_idx     <= w_idxNext;
              r_keycode <= {8'h00, keyOf(w_idxNext)};
            end else if (DEMO_LOOP) begin
              r_idx     <= 3'd0;
              r_keycode <= {8'h00, keyOf(3'd0)};
            end else begin
              r_state      <= LIVE;
              r_demoActive <= 1'b0;
              r_idx        <= 3'd0;
              r_idleCnt    <= '0;
              r_keycode    <= 16'h0000;
            end
          end else begin
            r_durCnt <= r_durCnt + 8'd1;
          end
        end
        default: r_state <= LIVE;
      endcase
    end
  end

  assign bus.keycode_out = r_keycode;
  assign bus.demo_active = r_demoActive;
  assign bus.script_idx  = r_idx;

endmodule

// File: tb/tb_keycode_autopilot.sv
// Randomised bench comparing a looping and a one-shot autopilot against a
// frame-position model of the attract script.
module tb_keycode_autopilot;
  localparam int IDLE = 4;
  localparam int PERIOD = 240;
  localparam logic [7:0] KEY [8] = '{8'h07, 8'h16, 8'h04, 8'h1A, 8'h07, 8'h1A, 8'h04, 8'h16};
  localparam int DUR [8] = '{40, 40, 40, 40, 20, 20, 20, 20};

  logic frame_clk = 1'b0;
  logic Reset = 1'b1;
  int checkCount = 0;
  int passCount = 0;

  keycode_autopilot_if busA ();
  keycode_autopilot_if busB ();

  keycode_autopilot #(.IDLE_FRAMES(IDLE), .DEMO_LOOP(1'b1)) dutLoop (
    .frame_clk(frame_clk), .Reset(Reset), .bus(busA.slave));
  keycode_autopilot #(.IDLE_FRAMES(IDLE), .DEMO_LOOP(1'b0)) dutOnce (
    .frame_clk(frame_clk), .Reset(Reset), .bus(busB.slave));

  always #5 frame_clk = ~frame_clk;

  logic [19:0] dutVec [2];
  assign dutVec[0] = {busA.keycode_out, busA.demo_active, busA.script_idx};
  assign dutVec[1] = {busB.keycode_out, busB.demo_active, busB.script_idx};

  // Model: index 0 loops, index 1 returns to live after one pass
  int mMode [2];
  int mZero [2];
  int mT [2];
  logic [15:0] mOut [2];

  function automatic int stepAt(input int t);
    int acc = 0;
    for (int i = 0; i < 8; i++) begin
      acc += DUR[i];
      if (t < acc) return i;
    end
    return 0;
  endfunction

  function automatic logic [19:0] expVec(input int d);
    logic [2:0] idx;
    idx = (mMode[d] == 1) ? 3'(stepAt(mT[d])) : 3'd0;
    return {mOut[d], (mMode[d] == 1), idx};
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mMode[d] = 0; mZero[d] = 0; mT[d] = 0; mOut[d] = 16'h0000;
    end
  endtask

  task automatic modelEdge(input logic [15:0] live, input logic en);
    for (int d = 0; d < 2; d++) begin
      if (mMode[d] == 0) begin
        mOut[d] = live;
        if (live == 16'h0000 && en) begin
          mZero[d]++;
          if (mZero[d] == IDLE) begin
            mMode[d] = 1; mT[d] = 0; mZero[d] = 0;
            mOut[d] = {8'h00, KEY[0]};
          end
        end else begin
          mZero[d] = 0;
        end
      end else if (live != 16'h0000 || !en) begin
        mMode[d] = 0; mOut[d] = live; mZero[d] = 0;
      end else begin
        mT[d]++;
        if (mT[d] == PERIOD) begin
          if (d == 0) mT[d] = 0;
          else begin mMode[d] = 0; mOut[d] = 16'h0000; mZero[d] = 0; end
        end
        if (mMode[d] == 1) mOut[d] = {8'h00, KEY[stepAt(mT[d])]};
      end
    end
  endtask

  task automatic applyStimulus(input logic [15:0] live, input logic en);
    busA.live_keycode = live; busA.demo_enable = en;
    busB.live_keycode = live; busB.demo_enable = en;
    @(posedge frame_clk);
    #1;
    modelEdge(live, en);
  endtask

  task automatic test_reset();
    #12;
    for (int d = 0; d < 2; d++) begin
      checkCount++;
      if (dutVec[d] !== 20'h0) $display("[TB] FAIL reset_hold dut%0d got %h exp %h", d, dutVec[d], 20'h0);
      else passCount++;
    end
    #4 Reset = 1'b0;
  endtask

  task automatic test_live_passthrough();
    applyStimulus(16'h001A, 1'b1);
    checkCount++;
    if (busA.keycode_out !== 16'h001A) $display("[TB] FAIL live_001A got %h exp %h", busA.keycode_out, 16'h001A);
    else passCount++;
    applyStimulus(16'h0000, 1'b1);
    checkCount++;
    if (busA.keycode_out !== 16'h0000) $display("[TB] FAIL live_zero got %h exp %h", busA.keycode_out, 16'h0000);
    else passCount++;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(16'($urandom_range(1, 16'hFFFF)), 1'($urandom));
      for (int d = 0; d < 2; d++) begin
        checkCount++;
        if (dutVec[d] !== expVec(d)) $display("[TB] FAIL live_random dut%0d got %h exp %h", d, dutVec[d], expVec(d));
        else passCount++;
      end
    end
  endtask

  task automatic test_demo_entry();
    for (int i = 1; i <= IDLE; i++) begin
      applyStimulus(16'h0000, 1'b1);
      checkCount++;
      if (busA.demo_active !== (i == IDLE)) $display("[TB] FAIL entry_active_%0d got %b exp %b", i, busA.demo_active, (i == IDLE));
      else passCount++;
    end
    checkCount++;
    if (busA.keycode_out !== 16'h0007) $display("[TB] FAIL entry_key got %h exp %h", busA.keycode_out, 16'h0007);
    else passCount++;
    for (int i = 0; i < 40; i++) applyStimulus(16'h0000, 1'b1);
    checkCount++;
    if ({busA.keycode_out, busA.script_idx} !== {16'h0016, 3'd1})
      $display("[TB] FAIL step1 got %h/%0d exp 0016/1", busA.keycode_out, busA.script_idx);
    else passCount++;
  endtask

  task automatic test_script_wrap();
    for (int i = 0; i < PERIOD - 40; i++) begin
      applyStimulus(16'h0000, 1'b1);
      for (int d = 0; d < 2; d++) begin
        checkCount++;
        if (dutVec[d] !== expVec(d)) $display("[TB] FAIL script_walk dut%0d t%0d got %h exp %h", d, i, dutVec[d], expVec(d));
        else passCount++;
      end
    end
    checkCount++;
    if (dutVec[0] !== {16'h0007, 1'b1, 3'd0}) $display("[TB] FAIL wrap_loop got %h exp %h", dutVec[0], {16'h0007, 1'b1, 3'd0});
    else passCount++;
    checkCount++;
    if (dutVec[1] !== 20'h0) $display("[TB] FAIL wrap_once got %h exp %h", dutVec[1], 20'h0);
    else passCount++;
    for (int i = 1; i <= IDLE; i++) begin
      applyStimulus(16'h0000, 1'b1);
      checkCount++;
      if (busB.demo_active !== (i == IDLE)) $display("[TB] FAIL once_reentry_%0d got %b exp %b", i, busB.demo_active, (i == IDLE));
      else passCount++;
    end
  endtask

  task automatic test_abort();
    while (mT[0] < 80) applyStimulus(16'h0000, 1'b1);
    checkCount++;
    if (busA.script_idx !== 3'd2) $display("[TB] FAIL abort_setup got %0d exp 2", busA.script_idx);
    else passCount++;
    applyStimulus(16'h0416, 1'b1);
    checkCount++;
    if ({busA.demo_active, busA.keycode_out} !== {1'b0, 16'h0416})
      $display("[TB] FAIL abort_same_edge got %b/%h exp 0/0416", busA.demo_active, busA.keycode_out);
    else passCount++;
    for (int i = 1; i <= IDLE; i++) begin
      applyStimulus(16'h0000, 1'b1);
      for (int d = 0; d < 2; d++) begin
        checkCount++;
        if (dutVec[d] !== expVec(d)) $display("[TB] FAIL abort_reentry dut%0d got %h exp %h", d, dutVec[d], expVec(d));
        else passCount++;
      end
    end
  endtask

  task automatic test_disable();
    applyStimulus(16'h0000, 1'b0);
    checkCount++;
    if ({busA.demo_active, busA.keycode_out} !== {1'b0, 16'h0000})
      $display("[TB] FAIL disable_exit got %b/%h exp 0/0000", busA.demo_active, busA.keycode_out);
    else passCount++;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(16'h0000, 1'b0);
      checkCount++;
      if ((busA.demo_active | busB.demo_active) !== 1'b0) $display("[TB] FAIL disable_hold edge%0d got 1 exp 0", i);
      else passCount++;
    end
    for (int i = 1; i <= IDLE; i++) begin
      applyStimulus(16'h0000, 1'b1);
      checkCount++;
      if (busA.demo_active !== (i == IDLE)) $display("[TB] FAIL disable_idle_clear_%0d got %b exp %b", i, busA.demo_active, (i == IDLE));
      else passCount++;
    end
  endtask

  task automatic test_random_mix();
    for (int i = 0; i < 600; i++) begin
      logic [15:0] live;
      logic en;
      live = ($urandom_range(0, 60) == 0) ? 16'($urandom_range(1, 16'hFFFF)) : 16'h0000;
      en = ($urandom_range(0, 120) != 0);
      applyStimulus(live, en);
      for (int d = 0; d < 2; d++) begin
        checkCount++;
        if (dutVec[d] !== expVec(d)) $display("[TB] FAIL random_mix dut%0d edge%0d got %h exp %h", d, i, dutVec[d], expVec(d));
        else passCount++;
      end
    end
  endtask

  task automatic test_reset_async();
    int budget = 20;
    while (mMode[0] != 1 && budget > 0) begin
      applyStimulus(16'h0000, 1'b1);
      budget--;
    end
    checkCount++;
    if (busA.demo_active !== 1'b1) $display("[TB] FAIL reset_setup got %b exp 1", busA.demo_active);
    else passCount++;
    #3 Reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkCount++;
      if (dutVec[d] !== 20'h0) $display("[TB] FAIL reset_async dut%0d got %h exp %h", d, dutVec[d], 20'h0);
      else passCount++;
    end
    modelReset();
    #2 Reset = 1'b0;
    applyStimulus(16'h0000, 1'b1);
    checkCount++;
    if (dutVec[0] !== expVec(0)) $display("[TB] FAIL reset_recover got %h exp %h", dutVec[0], expVec(0));
    else passCount++;
  endtask

  initial begin
    busA.live_keycode = 16'h0000; busA.demo_enable = 1'b1;
    busB.live_keycode = 16'h0000; busB.demo_enable = 1'b1;
    modelReset();
    test_reset();
    test_live_passthrough();
    applyStimulus(16'h0004, 1'b1);
    test_demo_entry();
    test_script_wrap();
    test_abort();
    test_disable();
    test_random_mix();
    test_reset_async();
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
